// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, sequencer FSM states and the
// highest legal opcode used for illegal-code detection.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_ADD = 4'd2,
        OP_INC = 4'd3,
        OP_DEC = 4'd4,
        OP_NOT = 4'd5,
        OP_SUB = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

    localparam logic [3:0] ALU_OP_LAST = 4'd9;

endpackage

// File: rtl/alu_op_sequencer.sv
// Registered command front-end for the lab ALU: issue one op, capture its result.
// Optional `ALU_CHAIN_EN: cmd_chain substitutes the last legal result for operand A.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [n-1:0] cmd_a,
    input  logic [n-1:0] cmd_b,
    input  logic         cmd_flag_in,
    input  logic         cmd_chain,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic         alu_flag_in,
    output logic [3:0]   alu_control,
    input  logic [n-1:0] alu_result,
    input  logic [1:0]   alu_flags,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_result,
    output logic [1:0]   rsp_flags,
    output logic         rsp_err,
    output logic [7:0]   op_count
);

    seq_state_e   state_q;
    logic [n-1:0] alu_a_q;
    logic [n-1:0] alu_b_q;
    logic         alu_fin_q;
    alu_op_e      alu_ctl_q;
    logic [n-1:0] rsp_result_q;
    logic [1:0]   rsp_flags_q;
    logic         rsp_err_q;
    logic [7:0]   op_count_q;
    logic [n-1:0] alu_a_d;
    logic         illegal_op;

    assign illegal_op = (cmd_op > ALU_OP_LAST);

`ifdef ALU_CHAIN_EN
    logic [n-1:0] last_q;
    assign alu_a_d = cmd_chain ? last_q : cmd_a;
`else
    logic unused_chain;
    assign unused_chain = cmd_chain;
    assign alu_a_d      = cmd_a;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_fin_q    <= 1'b0;
            alu_ctl_q    <= OP_AND;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
            op_count_q   <= '0;
`ifdef ALU_CHAIN_EN
            last_q       <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        // Illegal codes bypass the ALU so its inputs keep the last legal op.
                        if (illegal_op) begin
                            rsp_result_q <= '0;
                            rsp_flags_q  <= '0;
                            rsp_err_q    <= 1'b1;
                            state_q      <= ST_RESP;
                        end else begin
                            alu_a_q   <= alu_a_d;
                            alu_b_q   <= cmd_b;
                            alu_fin_q <= cmd_flag_in;
                            alu_ctl_q <= alu_op_e'(cmd_op);
                            state_q   <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    rsp_result_q <= alu_result;
                    rsp_flags_q  <= alu_flags;
                    rsp_err_q    <= 1'b0;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        op_count_q <= op_count_q + 8'd1;
`ifdef ALU_CHAIN_EN
                        if (!rsp_err_q) begin
                            last_q <= rsp_result_q;
                        end
`endif
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_flag_in = alu_fin_q;
    assign alu_control = alu_ctl_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_flags   = rsp_flags_q;
    assign rsp_err     = rsp_err_q;
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU attached to its alu_* ports.
module tb_alu_op_sequencer;

    localparam int n = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [3:0]   cmd_op = '0;
    logic [n-1:0] cmd_a = '0;
    logic [n-1:0] cmd_b = '0;
    logic         cmd_flag_in = 1'b0;
    logic         cmd_chain = 1'b0;
    logic [n-1:0] alu_a;
    logic [n-1:0] alu_b;
    logic         alu_flag_in;
    logic [3:0]   alu_control;
    logic [n-1:0] alu_result;
    logic [1:0]   alu_flags;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [n-1:0] rsp_result;
    logic [1:0]   rsp_flags;
    logic         rsp_err;
    logic [7:0]   op_count;

    int checks = 0;
    int errors = 0;
    logic [n-1:0] chain_exp;

    always #5 clk = ~clk;

    alu_op_sequencer #(.n(n)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_flag_in(cmd_flag_in), .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_flag_in(alu_flag_in), .alu_control(alu_control),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .op_count(op_count)
    );

    // Lab ALU stand-in: flags = {carry/borrow, zero}
    logic [n:0] w;
    always_comb begin
        w = '0;
        case (alu_control)
            4'd0: w = {1'b0, alu_a & alu_b};
            4'd1: w = {1'b0, alu_a | alu_b};
            4'd2: w = {1'b0, alu_a} + {1'b0, alu_b} + {{n{1'b0}}, alu_flag_in};
            4'd3: w = {1'b0, alu_a} + 1'b1;
            4'd4: w = {1'b0, alu_a} - 1'b1;
            4'd5: w = {1'b0, ~alu_a};
            4'd6: w = {1'b0, alu_a} - {1'b0, alu_b} - {{n{1'b0}}, alu_flag_in};
            4'd7: w = {1'b0, alu_a ^ alu_b};
            4'd8: w = {alu_a, alu_flag_in};
            4'd9: w = {alu_a[0], alu_flag_in, alu_a[n-1:1]};
            default: w = '0;
        endcase
        alu_result = w[n-1:0];
        alu_flags  = {w[n], (w[n-1:0] == '0)};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [n-1:0] a, input logic [n-1:0] b,
                         input logic fin, input logic chain);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_flag_in = fin;
        cmd_chain   = chain;
    endtask

    initial begin
        // Reset
        step(); step();
        rst = 1'b0;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_op_count", 32'(op_count), 32'h0);
        chk("rst_alu_a", 32'(alu_a), 32'h0);
        chk("rst_rsp_result", 32'(rsp_result), 32'h0);

        // Add with carry: 7 + 5 + 1 = 0xD
        issue(4'd2, 4'd7, 4'd5, 1'b1, 1'b0);
        step();
        cmd_valid = 1'b0;
        chk("add_exec_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("add_exec_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("add_alu_a", 32'(alu_a), 32'h7);
        chk("add_alu_control", 32'(alu_control), 32'h2);
        step();
        chk("add_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("add_result", 32'(rsp_result), 32'hD);
        chk("add_flags", 32'(rsp_flags), 32'h0);
        chk("add_err", 32'(rsp_err), 32'h0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("add_retire_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("add_retire_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("add_op_count", 32'(op_count), 32'h1);

        // Sub wrap-around: 2 - 3 = 0xF with borrow
        issue(4'd6, 4'd2, 4'd3, 1'b0, 1'b0);
        step();
        cmd_valid = 1'b0;
        step();
        chk("sub_result", 32'(rsp_result), 32'hF);
        chk("sub_flags", 32'(rsp_flags), 32'h2);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("sub_hold_alu_a", 32'(alu_a), 32'h2);
        chk("sub_hold_alu_b", 32'(alu_b), 32'h3);
        chk("sub_op_count", 32'(op_count), 32'h2);

        // Illegal opcode 12: response one cycle after acceptance, ALU inputs untouched
        issue(4'd12, 4'd9, 4'd9, 1'b1, 1'b0);
        step();
        cmd_valid = 1'b0;
        chk("ill_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("ill_err", 32'(rsp_err), 32'h1);
        chk("ill_result", 32'(rsp_result), 32'h0);
        chk("ill_flags", 32'(rsp_flags), 32'h0);
        chk("ill_alu_control", 32'(alu_control), 32'h6);
        chk("ill_alu_a", 32'(alu_a), 32'h2);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("ill_op_count", 32'(op_count), 32'h3);

        // Backpressure: xor 0xA^0x3 = 0x9 held in RESP while another command waits
        issue(4'd7, 4'hA, 4'h3, 1'b0, 1'b0);
        step();
        issue(4'd0, 4'hC, 4'hA, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_result", 32'(rsp_result), 32'h9);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'h0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp_retire_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("bp_retire_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("bp_retire_alu_control", 32'(alu_control), 32'h7);
        chk("bp_op_count", 32'(op_count), 32'h4);
        step();
        cmd_valid = 1'b0;
        chk("bp_held_alu_control", 32'(alu_control), 32'h0);
        chk("bp_held_alu_a", 32'(alu_a), 32'hC);
        step();
        chk("bp_held_result", 32'(rsp_result), 32'h8);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp_held_op_count", 32'(op_count), 32'h5);

        // Chaining: 3 + 4 = 7, then inc with cmd_chain
        issue(4'd2, 4'd3, 4'd4, 1'b0, 1'b0);
        step();
        cmd_valid = 1'b0;
        step();
        chk("chain_first_result", 32'(rsp_result), 32'h7);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        issue(4'd3, 4'd0, 4'd0, 1'b0, 1'b1);
        step();
        cmd_valid = 1'b0;
        cmd_chain = 1'b0;
        step();
`ifdef ALU_CHAIN_EN
        chain_exp = 4'd8;
`else
        chain_exp = 4'd1;
`endif
        chk("chain_result", 32'(rsp_result), 32'(chain_exp));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("chain_op_count", 32'(op_count), 32'h7);

        // Reset while in EXEC drops the transaction
        issue(4'd2, 4'd1, 4'd1, 1'b0, 1'b0);
        step();
        cmd_valid = 1'b0;
        chk("rexec_in_exec", 32'(cmd_ready), 32'h0);
        rst = 1'b1;
        rsp_ready = 1'b1;
        step();
        rst = 1'b0;
        chk("rexec_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rexec_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("rexec_op_count", 32'(op_count), 32'h0);
        chk("rexec_alu_control", 32'(alu_control), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rexec_no_rsp", 32'(rsp_valid), 32'h0);
        end
        chk("rexec_op_count_after", 32'(op_count), 32'h0);

        // op_count wrap: illegal ops with rsp_ready high take two cycles each
        issue(4'd15, 4'd0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 510; i++) step();
        chk("wrap_255", 32'(op_count), 32'hFF);
        step(); step();
        cmd_valid = 1'b0;
        chk("wrap_0", 32'(op_count), 32'h0);
        step();
        chk("wrap_idle", 32'(cmd_ready), 32'h1);
        rsp_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
